// File: rtl/ring_seq_if.sv
// Handshake bundle between a ring-pattern source and the ring sequence checker.
interface ring_seq_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned IW = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic             en;
  logic [N-1:0]     ring_in;
  logic             clr_err;
  logic [IW-1:0]    idx;
  logic             idx_valid;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, ring_in, clr_err,
    input  idx, idx_valid, locked, err_pulse, err_count
  );

  modport slave (
    input  en, ring_in, clr_err,
    output idx, idx_valid, locked, err_pulse, err_count
  );
endinterface

// File: rtl/ring_sequence_checker.sv
// Decodes a one-hot ring pattern, locks onto its rotate-left sequence and
// flags/counts deviations once locked.
module ring_sequence_checker #(
  parameter int unsigned N          = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  ring_seq_if.slave  bus
);
  localparam int unsigned IW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     prev, prev_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic [N-1:0]     rot;
  logic             one_hot;
  logic             match;
  logic             seq_err;

  logic [IW-1:0]    idx_q, idx_nxt, idx_enc;
  logic             idx_valid_q, idx_valid_nxt;
  logic             locked_q, err_pulse_q;
  logic [ERR_W-1:0] err_count_q, err_count_nxt;

  assign one_hot = (bus.ring_in != '0) && ((bus.ring_in & (bus.ring_in - N'(1))) == '0);
  assign rot     = {prev[N-2:0], prev[N-1]};
  assign match   = one_hot && (bus.ring_in == rot);
  assign cnt_inc = cnt + CW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      prev  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: search, acquire LOCK_COUNT consecutive rotations, then track
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prev_nxt  = prev;
    seq_err   = 1'b0;
    if (bus.en) begin
      prev_nxt = bus.ring_in;
      case (state)
        SEARCH: begin
          if (one_hot) begin
            state_nxt = ACQUIRE;
            cnt_nxt   = CW'(1);
          end
        end
        ACQUIRE: begin
          if (match) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(LOCK_COUNT)) state_nxt = LOCKED;
          end else if (one_hot) begin
            cnt_nxt = CW'(1);
          end else begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
            seq_err   = 1'b1;
          end
        end
        default: begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output next values: index decode and saturating error count
  always_comb begin
    idx_enc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.ring_in[i]) idx_enc = IW'(i);
    end

    idx_nxt       = idx_q;
    idx_valid_nxt = 1'b0;
    if (bus.en && one_hot) begin
      idx_nxt       = idx_enc;
      idx_valid_nxt = 1'b1;
    end

    err_count_nxt = err_count_q;
    if (bus.clr_err) begin
      err_count_nxt = '0;
    end else if (seq_err && (err_count_q != ERR_MAX)) begin
      err_count_nxt = err_count_q + ERR_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      idx_q       <= idx_nxt;
      idx_valid_q <= idx_valid_nxt;
      locked_q    <= (state_nxt == LOCKED);
      err_pulse_q <= seq_err;
      err_count_q <= err_count_nxt;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = idx_valid_q;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
endmodule
